// File: rtl/reg_write_port_arbiter_if.sv
// Bundle for the register-file write-port front end.
// The master side is the set of writeback requesters; the slave side is the
// arbiter, which also drives the registered write port toward the bank.
//
// Handshake (valid/ready): channel i transfers in a cycle where
// wr_valid_i[i] & wr_ready_o[i] are both 1. Once wr_valid_i[i] is raised, the
// requester keeps it, its address and its data stable until that transfer.
// wr_ready_o is combinational, never 1 without the matching valid, and at most
// one bit is set per cycle.
interface reg_write_port_arbiter_if #(
  parameter int WORD_LENGTH = 32,
  parameter int BITS        = 5,
  parameter int NUM_REGS    = 32,
  parameter int CHANNELS    = 2
);

  // requester side
  logic [CHANNELS-1:0]             wr_valid_i;
  logic [CHANNELS*BITS-1:0]        wr_addr_i;
  logic [CHANNELS*WORD_LENGTH-1:0] wr_data_i;
  logic [CHANNELS-1:0]             wr_ready_o;

  // registered write port toward the register bank
  logic [NUM_REGS-1:0]             we_o;
  logic [BITS-1:0]                 waddr_o;
  logic [WORD_LENGTH-1:0]          wdata_o;
  logic                            wr_fire_o;
  logic                            drop_o;

  modport master (
    output wr_valid_i, wr_addr_i, wr_data_i,
    input  wr_ready_o, we_o, waddr_o, wdata_o, wr_fire_o, drop_o
  );

  modport slave (
    input  wr_valid_i, wr_addr_i, wr_data_i,
    output wr_ready_o, we_o, waddr_o, wdata_o, wr_fire_o, drop_o
  );

endinterface

// File: rtl/reg_write_port_arbiter.sv
// Register-file write-port front end.
// Picks one of CHANNELS write requesters per cycle (fixed priority or
// round-robin), decodes the winning address into a one-hot per-register write
// enable and registers enable, address and data one cycle later.
// Requests that cannot produce an enable (register 0 when it is read-only, or
// an address past the implemented registers) are still consumed and flagged
// on drop_o so a writer is never stalled by a bad address.
module reg_write_port_arbiter #(
  parameter int WORD_LENGTH       = 32,
  parameter int BITS              = 5,
  parameter int NUM_REGS          = 32,
  parameter int CHANNELS          = 2,
  parameter int ARB_MODE          = 0,
  parameter int ZERO_REG_WRITABLE = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  reg_write_port_arbiter_if.slave bus
);

  localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // (base + offs) mod CHANNELS, for base < CHANNELS and offs <= CHANNELS
  function automatic logic [PTR_W-1:0] wrap_idx(input int base, input int offs);
    int s;
    s = base + offs;
    if (s >= CHANNELS) s = s - CHANNELS;
    return PTR_W'(s);
  endfunction

  // round-robin search start; unused (held at 0) in fixed-priority mode
  logic [PTR_W-1:0]       rr_ptr;

  // arbitration results
  logic                   found;
  logic [PTR_W-1:0]       winner;
  logic [PTR_W-1:0]       idx;
  logic [CHANNELS-1:0]    grant;

  // selected request and its decode
  logic [BITS-1:0]        sel_addr;
  logic [WORD_LENGTH-1:0] sel_data;
  logic                   addr_en;
  logic [NUM_REGS-1:0]    dec;

  // registered write port
  logic [NUM_REGS-1:0]    we_q;
  logic [BITS-1:0]        waddr_q;
  logic [WORD_LENGTH-1:0] wdata_q;
  logic                   fire_q;
  logic                   drop_q;

  // Arbitration: choose at most one valid channel; nothing is granted while
  // reset is high so requests pending in that cycle stay pending.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    grant  = '0;
    if (!reset) begin
      if (ARB_MODE == 0) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (!found && bus.wr_valid_i[i]) begin
            found  = 1'b1;
            winner = PTR_W'(i);
          end
        end
      end else begin
        for (int k = 0; k < CHANNELS; k++) begin
          idx = wrap_idx(int'(rr_ptr), k);
          if (!found && bus.wr_valid_i[idx]) begin
            found  = 1'b1;
            winner = idx;
          end
        end
      end
      if (found) grant[winner] = 1'b1;
    end
  end

  assign bus.wr_ready_o = grant;

  // Select the granted channel's address/data and decode the write enable.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) begin
        sel_addr = bus.wr_addr_i[i*BITS +: BITS];
        sel_data = bus.wr_data_i[i*WORD_LENGTH +: WORD_LENGTH];
      end
    end
    // register 0 is hard-wired unless explicitly made writable
    addr_en = (int'(sel_addr) < NUM_REGS) &&
              ((ZERO_REG_WRITABLE != 0) || (sel_addr != '0));
    dec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      dec[r] = addr_en && (int'(sel_addr) == r);
    end
  end

  // Round-robin pointer: advance past the winner on every grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (found && (ARB_MODE != 0)) begin
      rr_ptr <= wrap_idx(int'(winner), 1);
    end
  end

  // Output registers: pulse enable/fire/drop for one cycle per transfer;
  // address and data hold their last accepted values between transfers.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      fire_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else if (found) begin
      we_q    <= dec;
      waddr_q <= sel_addr;
      wdata_q <= sel_data;
      fire_q  <= 1'b1;
      drop_q  <= ~addr_en;
    end else begin
      we_q    <= '0;
      fire_q  <= 1'b0;
      drop_q  <= 1'b0;
    end
  end

  assign bus.we_o      = we_q;
  assign bus.waddr_o   = waddr_q;
  assign bus.wdata_o   = wdata_q;
  assign bus.wr_fire_o = fire_q;
  assign bus.drop_o    = drop_q;

endmodule

// File: tb/tb_reg_write_port_arbiter.sv
// Directed bench for reg_write_port_arbiter: three instances (fixed priority,
// round-robin, 16 implemented registers), shared clock and reset.
module tb_reg_write_port_arbiter;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  reg_write_port_arbiter_if #(.WORD_LENGTH(32), .BITS(5), .NUM_REGS(32), .CHANNELS(2)) bus_fix ();
  reg_write_port_arbiter_if #(.WORD_LENGTH(32), .BITS(5), .NUM_REGS(32), .CHANNELS(2)) bus_rr ();
  reg_write_port_arbiter_if #(.WORD_LENGTH(32), .BITS(5), .NUM_REGS(16), .CHANNELS(2)) bus_n16 ();

  reg_write_port_arbiter #(.WORD_LENGTH(32), .BITS(5), .NUM_REGS(32), .CHANNELS(2),
                           .ARB_MODE(0), .ZERO_REG_WRITABLE(0))
    dut_fix (.clk(clk), .reset(reset), .bus(bus_fix));

  reg_write_port_arbiter #(.WORD_LENGTH(32), .BITS(5), .NUM_REGS(32), .CHANNELS(2),
                           .ARB_MODE(1), .ZERO_REG_WRITABLE(0))
    dut_rr (.clk(clk), .reset(reset), .bus(bus_rr));

  reg_write_port_arbiter #(.WORD_LENGTH(32), .BITS(5), .NUM_REGS(16), .CHANNELS(2),
                           .ARB_MODE(0), .ZERO_REG_WRITABLE(0))
    dut_n16 (.clk(clk), .reset(reset), .bus(bus_n16));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver: idle all requesters
  task automatic idle_all();
    bus_fix.wr_valid_i = '0; bus_fix.wr_addr_i = '0; bus_fix.wr_data_i = '0;
    bus_rr.wr_valid_i  = '0; bus_rr.wr_addr_i  = '0; bus_rr.wr_data_i  = '0;
    bus_n16.wr_valid_i = '0; bus_n16.wr_addr_i = '0; bus_n16.wr_data_i = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_fix.wr_valid_i = 2'b11; bus_fix.wr_addr_i = {5'd7, 5'd3};
    bus_rr.wr_valid_i  = 2'b11; bus_rr.wr_addr_i  = {5'd7, 5'd3};
    #1;
    total++; if (bus_fix.wr_ready_o !== 2'b00) begin bad++; $display("FAIL reset_ready_fix: got %b want 00", bus_fix.wr_ready_o); end
    total++; if (bus_rr.wr_ready_o !== 2'b00) begin bad++; $display("FAIL reset_ready_rr: got %b want 00", bus_rr.wr_ready_o); end
    @(posedge clk); #1;
    total++; if (bus_fix.we_o !== 32'h0) begin bad++; $display("FAIL reset_we: got %h want 0", bus_fix.we_o); end
    total++; if (bus_fix.wr_fire_o !== 1'b0) begin bad++; $display("FAIL reset_fire: got %b want 0", bus_fix.wr_fire_o); end
    total++; if (bus_fix.drop_o !== 1'b0) begin bad++; $display("FAIL reset_drop: got %b want 0", bus_fix.drop_o); end
    total++; if (bus_fix.waddr_o !== 5'd0) begin bad++; $display("FAIL reset_waddr: got %0d want 0", bus_fix.waddr_o); end
    total++; if (bus_fix.wdata_o !== 32'h0) begin bad++; $display("FAIL reset_wdata: got %h want 0", bus_fix.wdata_o); end
    total++; if (bus_rr.we_o !== 32'h0) begin bad++; $display("FAIL reset_we_rr: got %h want 0", bus_rr.we_o); end
    @(negedge clk);
    idle_all();
    reset = 1'b0;
  endtask

  task automatic test_single_write();
    @(negedge clk);
    bus_fix.wr_valid_i = 2'b01; bus_fix.wr_addr_i = {5'd0, 5'd5}; bus_fix.wr_data_i = {32'h0, 32'hA5A50001};
    #1;
    total++; if (bus_fix.wr_ready_o !== 2'b01) begin bad++; $display("FAIL single_ready: got %b want 01", bus_fix.wr_ready_o); end
    @(posedge clk); #1;
    total++; if (bus_fix.we_o !== 32'h00000020) begin bad++; $display("FAIL single_we: got %h want 00000020", bus_fix.we_o); end
    total++; if (bus_fix.wdata_o !== 32'hA5A50001) begin bad++; $display("FAIL single_wdata: got %h want a5a50001", bus_fix.wdata_o); end
    total++; if (bus_fix.waddr_o !== 5'd5) begin bad++; $display("FAIL single_waddr: got %0d want 5", bus_fix.waddr_o); end
    total++; if (bus_fix.wr_fire_o !== 1'b1) begin bad++; $display("FAIL single_fire: got %b want 1", bus_fix.wr_fire_o); end
    total++; if (bus_fix.drop_o !== 1'b0) begin bad++; $display("FAIL single_drop: got %b want 0", bus_fix.drop_o); end
    @(negedge clk);
    idle_all();
    #1;
    total++; if (bus_fix.wr_ready_o !== 2'b00) begin bad++; $display("FAIL idle_ready: got %b want 00", bus_fix.wr_ready_o); end
    @(posedge clk); #1;
    total++; if (bus_fix.we_o !== 32'h0) begin bad++; $display("FAIL idle_we: got %h want 0", bus_fix.we_o); end
    total++; if (bus_fix.wr_fire_o !== 1'b0) begin bad++; $display("FAIL idle_fire: got %b want 0", bus_fix.wr_fire_o); end
    total++; if (bus_fix.waddr_o !== 5'd5) begin bad++; $display("FAIL idle_waddr_hold: got %0d want 5", bus_fix.waddr_o); end
    total++; if (bus_fix.wdata_o !== 32'hA5A50001) begin bad++; $display("FAIL idle_wdata_hold: got %h want a5a50001", bus_fix.wdata_o); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    bus_fix.wr_valid_i = 2'b01; bus_fix.wr_addr_i = {5'd0, 5'd0}; bus_fix.wr_data_i = {32'h0, 32'h12345678};
    #1;
    total++; if (bus_fix.wr_ready_o !== 2'b01) begin bad++; $display("FAIL zero_ready: got %b want 01", bus_fix.wr_ready_o); end
    @(posedge clk); #1;
    total++; if (bus_fix.we_o !== 32'h0) begin bad++; $display("FAIL zero_we: got %h want 0", bus_fix.we_o); end
    total++; if (bus_fix.drop_o !== 1'b1) begin bad++; $display("FAIL zero_drop: got %b want 1", bus_fix.drop_o); end
    total++; if (bus_fix.wr_fire_o !== 1'b1) begin bad++; $display("FAIL zero_fire: got %b want 1", bus_fix.wr_fire_o); end
    @(negedge clk);
    idle_all();
    @(posedge clk); #1;
    total++; if (bus_fix.drop_o !== 1'b0) begin bad++; $display("FAIL zero_drop_clear: got %b want 0", bus_fix.drop_o); end
  endtask

  task automatic test_fixed_priority();
    @(negedge clk);
    bus_fix.wr_valid_i = 2'b11; bus_fix.wr_addr_i = {5'd7, 5'd3}; bus_fix.wr_data_i = {32'h11110007, 32'h22220003};
    #1;
    total++; if (bus_fix.wr_ready_o !== 2'b01) begin bad++; $display("FAIL fixed_ready1: got %b want 01", bus_fix.wr_ready_o); end
    @(posedge clk); #1;
    total++; if (bus_fix.we_o !== 32'h8) begin bad++; $display("FAIL fixed_we1: got %h want 00000008", bus_fix.we_o); end
    total++; if (bus_fix.wdata_o !== 32'h22220003) begin bad++; $display("FAIL fixed_wdata1: got %h want 22220003", bus_fix.wdata_o); end
    // ch0 was accepted and withdraws; ch1 still holds its request
    @(negedge clk);
    bus_fix.wr_valid_i = 2'b10;
    #1;
    total++; if (bus_fix.wr_ready_o !== 2'b10) begin bad++; $display("FAIL fixed_ready2: got %b want 10", bus_fix.wr_ready_o); end
    @(posedge clk); #1;
    total++; if (bus_fix.we_o !== 32'h80) begin bad++; $display("FAIL fixed_we2: got %h want 00000080", bus_fix.we_o); end
    total++; if (bus_fix.wdata_o !== 32'h11110007) begin bad++; $display("FAIL fixed_wdata2: got %h want 11110007", bus_fix.wdata_o); end
    total++; if (bus_fix.waddr_o !== 5'd7) begin bad++; $display("FAIL fixed_waddr2: got %0d want 7", bus_fix.waddr_o); end
    @(negedge clk);
    idle_all();
  endtask

  task automatic test_round_robin();
    logic       exp_ptr;
    logic [1:0] exp_ready;
    logic [31:0] exp_we;
    exp_ptr = 1'b0;
    @(negedge clk);
    bus_rr.wr_valid_i = 2'b11; bus_rr.wr_addr_i = {5'd2, 5'd1}; bus_rr.wr_data_i = {32'hBBBB0002, 32'hAAAA0001};
    for (int c = 0; c < 4; c++) begin
      exp_ready = exp_ptr ? 2'b10 : 2'b01;
      exp_we    = exp_ptr ? 32'h4 : 32'h2;
      #1;
      total++; if (bus_rr.wr_ready_o !== exp_ready) begin bad++; $display("FAIL rr_ready c%0d: got %b want %b", c, bus_rr.wr_ready_o, exp_ready); end
      @(posedge clk); #1;
      total++; if (bus_rr.we_o !== exp_we) begin bad++; $display("FAIL rr_we c%0d: got %h want %h", c, bus_rr.we_o, exp_we); end
      total++; if (bus_rr.wr_fire_o !== 1'b1) begin bad++; $display("FAIL rr_fire c%0d: got %b want 1", c, bus_rr.wr_fire_o); end
      exp_ptr = ~exp_ptr;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    // valids still held from round-robin; one more grant moves the pointer to ch1
    #1;
    total++; if (bus_rr.wr_ready_o !== 2'b01) begin bad++; $display("FAIL mid_pre_ready: got %b want 01", bus_rr.wr_ready_o); end
    @(negedge clk);
    #1;
    total++; if (bus_rr.wr_ready_o !== 2'b10) begin bad++; $display("FAIL mid_ptr_ready: got %b want 10", bus_rr.wr_ready_o); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (bus_rr.wr_ready_o !== 2'b00) begin bad++; $display("FAIL mid_reset_ready: got %b want 00", bus_rr.wr_ready_o); end
    @(posedge clk); #1;
    total++; if (bus_rr.we_o !== 32'h0) begin bad++; $display("FAIL mid_reset_we: got %h want 0", bus_rr.we_o); end
    total++; if (bus_rr.wr_fire_o !== 1'b0) begin bad++; $display("FAIL mid_reset_fire: got %b want 0", bus_rr.wr_fire_o); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (bus_rr.wr_ready_o !== 2'b01) begin bad++; $display("FAIL mid_after_ready: got %b want 01", bus_rr.wr_ready_o); end
    @(posedge clk); #1;
    total++; if (bus_rr.we_o !== 32'h2) begin bad++; $display("FAIL mid_after_we: got %h want 00000002", bus_rr.we_o); end
    @(negedge clk);
    idle_all();
  endtask

  task automatic test_boundary();
    @(negedge clk);
    bus_fix.wr_valid_i = 2'b01; bus_fix.wr_addr_i = {5'd0, 5'd31}; bus_fix.wr_data_i = {32'h0, 32'hDEADBEEF};
    bus_n16.wr_valid_i = 2'b01; bus_n16.wr_addr_i = {5'd0, 5'd20}; bus_n16.wr_data_i = {32'h0, 32'hCAFE0020};
    #1;
    total++; if (bus_n16.wr_ready_o !== 2'b01) begin bad++; $display("FAIL n16_ready: got %b want 01", bus_n16.wr_ready_o); end
    @(posedge clk); #1;
    total++; if (bus_fix.we_o !== 32'h80000000) begin bad++; $display("FAIL top_we: got %h want 80000000", bus_fix.we_o); end
    total++; if (bus_n16.we_o !== 16'h0) begin bad++; $display("FAIL n16_oob_we: got %h want 0000", bus_n16.we_o); end
    total++; if (bus_n16.drop_o !== 1'b1) begin bad++; $display("FAIL n16_oob_drop: got %b want 1", bus_n16.drop_o); end
    total++; if (bus_n16.wr_fire_o !== 1'b1) begin bad++; $display("FAIL n16_oob_fire: got %b want 1", bus_n16.wr_fire_o); end
    @(negedge clk);
    bus_fix.wr_valid_i = 2'b00;
    bus_n16.wr_addr_i = {5'd0, 5'd15};
    @(posedge clk); #1;
    total++; if (bus_n16.we_o !== 16'h8000) begin bad++; $display("FAIL n16_last_we: got %h want 8000", bus_n16.we_o); end
    total++; if (bus_n16.drop_o !== 1'b0) begin bad++; $display("FAIL n16_last_drop: got %b want 0", bus_n16.drop_o); end
    @(negedge clk);
    idle_all();
  endtask

  task automatic test_back_to_back();
    logic [4:0]  addr_tab [4];
    logic [31:0] we_tab   [4];
    logic        drop_tab [4];
    addr_tab = '{5'd9, 5'd0, 5'd12, 5'd30};
    we_tab   = '{32'h00000200, 32'h0, 32'h00001000, 32'h40000000};
    drop_tab = '{1'b0, 1'b1, 1'b0, 1'b0};
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      bus_fix.wr_valid_i = 2'b10;
      bus_fix.wr_addr_i  = {addr_tab[c], 5'd0};
      bus_fix.wr_data_i  = {32'h50000000 + 32'(c), 32'h0};
      #1;
      total++; if (bus_fix.wr_ready_o !== 2'b10) begin bad++; $display("FAIL b2b_ready c%0d: got %b want 10", c, bus_fix.wr_ready_o); end
      @(posedge clk); #1;
      total++; if (bus_fix.we_o !== we_tab[c]) begin bad++; $display("FAIL b2b_we c%0d: got %h want %h", c, bus_fix.we_o, we_tab[c]); end
      total++; if (bus_fix.drop_o !== drop_tab[c]) begin bad++; $display("FAIL b2b_drop c%0d: got %b want %b", c, bus_fix.drop_o, drop_tab[c]); end
      total++; if (bus_fix.wr_fire_o !== 1'b1) begin bad++; $display("FAIL b2b_fire c%0d: got %b want 1", c, bus_fix.wr_fire_o); end
      total++; if (bus_fix.wdata_o !== (32'h50000000 + 32'(c))) begin bad++; $display("FAIL b2b_wdata c%0d: got %h want %h", c, bus_fix.wdata_o, 32'h50000000 + 32'(c)); end
      @(negedge clk);
    end
    idle_all();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    idle_all();
    test_reset();
    test_single_write();
    test_zero_reg();
    test_fixed_priority();
    test_round_robin();
    test_reset_mid();
    test_boundary();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
